// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the EX-stage ALU sharing arbiter: ALU op codes, FSM states, arbitration
// modes.
package alu_share_arbiter_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbExec = 2'd1,
    ArbResp = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response signals of the ALU sharing arbiter. The slave modport is the
// arbiter's view; master is the surrounding requesters, ALU and consumer.
interface alu_share_arbiter_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [XLEN-1:0]  req0_a;
  logic [XLEN-1:0]  req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [XLEN-1:0]  req1_a;
  logic [XLEN-1:0]  req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic [3:0]       alu_op;
  logic [XLEN-1:0]  alu_a;
  logic [XLEN-1:0]  alu_b;
  logic [XLEN-1:0]  alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_data;
  logic             rsp_src;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_result,
    output rsp_valid, rsp_data, rsp_src, rsp_tag,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_tag,
    output req1_valid, req1_op, req1_a, req1_b, req1_tag,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_result,
    input  rsp_valid, rsp_data, rsp_src, rsp_tag,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// Two-way grant logic: round-robin pointer or fixed priority with an anti-starvation counter.
// Grants only while en is high; state advances only on an actual grant.
module alu_share_arbiter_rr_arbiter2
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] WaitMax = CntW'(MAX_WAIT);

  logic            rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    gnt        = 2'b00;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          if (ARB_MODE == ARB_FIXED) gnt = (wait_cnt_q == WaitMax) ? 2'b10 : 2'b01;
          else                       gnt = rr_ptr_q ? 2'b10 : 2'b01;
        end
        default: gnt = 2'b00;
      endcase
    end
    // Pointer always moves to the port that was not just served.
    if (gnt != 2'b00) rr_ptr_d = gnt[0];
    if (!req[1] || gnt[1]) begin
      wait_cnt_d = '0;
    end else if (gnt[0] && (wait_cnt_q != WaitMax)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute path (port 0) and an auxiliary unit
// (port 1): grant, register operands, capture the result, return it with source and tag.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst,
  alu_share_arbiter_if.slave bus
);
  arb_state_e       state_q, state_d;
  logic [1:0]       gnt;
  logic             grant_en;
  logic [3:0]       alu_op_q;
  logic [XLEN-1:0]  alu_a_q, alu_b_q;
  logic [TAG_W-1:0] tag_q;
  logic             src_q;
  logic             rsp_valid_q;
  logic [XLEN-1:0]  rsp_data_q;
  logic             rsp_src_q;
  logic [TAG_W-1:0] rsp_tag_q;

  // Reset suppresses any grant so no ready pulse escapes during a flush.
  assign grant_en = !rst && ((state_q == ArbIdle) || ((state_q == ArbResp) && bus.rsp_ready));

  alu_share_arbiter_rr_arbiter2 #(
    .ARB_MODE (ARB_MODE),
    .MAX_WAIT (MAX_WAIT)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.req1_valid, bus.req0_valid}),
    .en  (grant_en),
    .gnt (gnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ArbIdle: if (gnt != 2'b00) state_d = ArbExec;
      ArbExec: state_d = ArbResp;
      ArbResp: if (bus.rsp_ready) state_d = (gnt != 2'b00) ? ArbExec : ArbIdle;
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ArbIdle;
      alu_op_q    <= ALU_ADD;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      tag_q       <= '0;
      src_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_src_q   <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (gnt != 2'b00) begin
        alu_op_q <= gnt[1] ? bus.req1_op  : bus.req0_op;
        alu_a_q  <= gnt[1] ? bus.req1_a   : bus.req0_a;
        alu_b_q  <= gnt[1] ? bus.req1_b   : bus.req0_b;
        tag_q    <= gnt[1] ? bus.req1_tag : bus.req0_tag;
        src_q    <= gnt[1];
      end
      if (state_q == ArbExec) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= bus.alu_result;
        rsp_src_q   <= src_q;
        rsp_tag_q   <= tag_q;
      end else if ((state_q == ArbResp) && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_src    = rsp_src_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.busy       = (state_q != ArbIdle);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance (MAX_WAIT=4), each with
// a small combinational ALU model.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  alu_share_arbiter_if #(.XLEN(32), .TAG_W(4)) bus0 ();
  alu_share_arbiter_if #(.XLEN(32), .TAG_W(4)) bus1 ();

  alu_share_arbiter #(
    .XLEN(32), .TAG_W(4), .ARB_MODE(ARB_RR), .MAX_WAIT(4)
  ) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  alu_share_arbiter #(
    .XLEN(32), .TAG_W(4), .ARB_MODE(ARB_FIXED), .MAX_WAIT(4)
  ) dut_fx (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  assign bus0.alu_result = alu_f(bus0.alu_op, bus0.alu_a, bus0.alu_b);
  assign bus1.alu_result = alu_f(bus1.alu_op, bus1.alu_a, bus1.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] exp_g;
    logic       prev_src;
    rst = 1'b1;
    bus0.req0_valid = 0; bus0.req0_op = 0; bus0.req0_a = 0; bus0.req0_b = 0; bus0.req0_tag = 0;
    bus0.req1_valid = 0; bus0.req1_op = 0; bus0.req1_a = 0; bus0.req1_b = 0; bus0.req1_tag = 0;
    bus0.rsp_ready  = 0;
    bus1.req0_valid = 0; bus1.req0_op = 0; bus1.req0_a = 0; bus1.req0_b = 0; bus1.req0_tag = 0;
    bus1.req1_valid = 0; bus1.req1_op = 0; bus1.req1_a = 0; bus1.req1_b = 0; bus1.req1_tag = 0;
    bus1.rsp_ready  = 0;

    // Reset values
    repeat (2) @(posedge clk);
    mid();
    chk("rst_rsp_valid", bus0.rsp_valid, 0);
    chk("rst_rsp_data", bus0.rsp_data, 0);
    chk("rst_rsp_src", bus0.rsp_src, 0);
    chk("rst_rsp_tag", bus0.rsp_tag, 0);
    chk("rst_alu_op", bus0.alu_op, ALU_ADD);
    chk("rst_alu_a", bus0.alu_a, 0);
    chk("rst_alu_b", bus0.alu_b, 0);
    chk("rst_busy", {bus1.busy, bus0.busy}, 0);
    nxt();
    rst = 1'b0;

    // Idle: no valids for 10 cycles
    for (int i = 0; i < 10; i++) begin
      mid();
      chk("idle_busy_ready", {bus0.busy, bus0.req1_ready, bus0.req0_ready,
                              bus1.busy, bus1.req1_ready, bus1.req0_ready}, 0);
      nxt();
    end
    chk("idle_rsp_valid", bus0.rsp_valid, 0);
    chk("idle_alu_op", bus0.alu_op, ALU_ADD);

    // Round-robin contention, rr_ptr starts at port 0
    bus0.req0_op = ALU_SUB; bus0.req0_a = 10;    bus0.req0_b = 3;     bus0.req0_tag = 1;
    bus0.req1_op = ALU_XOR; bus0.req1_a = 'hF0;  bus0.req1_b = 'h0F;  bus0.req1_tag = 2;
    bus0.req0_valid = 1; bus0.req1_valid = 1; bus0.rsp_ready = 1;
    for (int i = 0; i <= 8; i++) begin
      mid();
      if (i % 2 == 0) exp_g = ((i / 2) % 2 == 1) ? 2'b10 : 2'b01;
      else            exp_g = 2'b00;
      chk("rr_grant", {bus0.req1_ready, bus0.req0_ready}, exp_g);
      if ((i % 2 == 0) && (i > 0)) begin
        chk("rr_rsp_valid", bus0.rsp_valid, 1);
        chk("rr_rsp_src", bus0.rsp_src, ((i / 2) % 2 == 0));
        chk("rr_rsp_data", bus0.rsp_data, ((i / 2) % 2 == 0) ? 32'hFF : 32'd7);
        chk("rr_rsp_tag", bus0.rsp_tag, ((i / 2) % 2 == 0) ? 2 : 1);
      end else begin
        chk("rr_rsp_idle", bus0.rsp_valid, 0);
      end
      nxt();
    end
    bus0.req0_valid = 0; bus0.req1_valid = 0;
    mid(); chk("rr_drain_busy", bus0.busy, 1);
    nxt(); mid();
    chk("rr_drain_data", bus0.rsp_data, 7);
    chk("rr_drain_src", bus0.rsp_src, 0);
    nxt(); mid();
    chk("rr_drain_idle", {bus0.busy, bus0.rsp_valid}, 0);
    nxt();

    // Single op
    bus0.req0_op = ALU_ADD; bus0.req0_a = 5; bus0.req0_b = 7; bus0.req0_tag = 3;
    bus0.req0_valid = 1;
    mid();
    chk("single_ready", {bus0.req1_ready, bus0.req0_ready}, 2'b01);
    nxt();
    bus0.req0_valid = 0;
    mid();
    chk("single_alu_a", bus0.alu_a, 5);
    chk("single_alu_b", bus0.alu_b, 7);
    chk("single_exec", {bus0.busy, bus0.rsp_valid}, 2'b10);
    nxt(); mid();
    chk("single_rsp_valid", bus0.rsp_valid, 1);
    chk("single_rsp_data", bus0.rsp_data, 12);
    chk("single_rsp_src", bus0.rsp_src, 0);
    chk("single_rsp_tag", bus0.rsp_tag, 3);
    nxt(); mid();
    chk("single_idle", {bus0.busy, bus0.rsp_valid}, 0);
    nxt();

    // Backpressure with port 1 pending; undefined op code passes through
    bus0.req0_op = ALU_AND; bus0.req0_a = 'hFF00; bus0.req0_b = 'h0FF0; bus0.req0_tag = 5;
    bus0.req0_valid = 1; bus0.rsp_ready = 0;
    mid(); chk("bp_grant0", bus0.req0_ready, 1);
    nxt();
    bus0.req0_valid = 0;
    bus0.req1_op = 4'hE; bus0.req1_a = 1; bus0.req1_b = 2; bus0.req1_tag = 9;
    bus0.req1_valid = 1;
    mid(); chk("bp_exec_noready", bus0.req1_ready, 0);
    nxt();
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("bp_hold_valid", bus0.rsp_valid, 1);
      chk("bp_hold_data", bus0.rsp_data, 32'h0F00);
      chk("bp_hold_src_tag", {bus0.rsp_src, bus0.rsp_tag}, 5'h05);
      chk("bp_hold_noready", {bus0.req1_ready, bus0.req0_ready}, 0);
      nxt();
    end
    bus0.rsp_ready = 1;
    mid();
    chk("bp_release_grant", {bus0.req1_ready, bus0.req0_ready}, 2'b10);
    chk("bp_release_valid", bus0.rsp_valid, 1);
    nxt();
    bus0.req1_valid = 0;
    mid();
    chk("bp_passthru_op", bus0.alu_op, 4'hE);
    chk("bp_alu_a", bus0.alu_a, 1);
    nxt(); mid();
    chk("bp_rsp_data", bus0.rsp_data, 32'hFFFF_FFFE);
    chk("bp_rsp_src_tag", {bus0.rsp_src, bus0.rsp_tag}, 5'h19);
    nxt(); mid();
    chk("bp_idle", bus0.busy, 0);
    nxt();

    // Reset while in EXEC
    bus0.req0_op = ALU_SUB; bus0.req0_a = 9; bus0.req0_b = 4; bus0.req0_tag = 7;
    bus0.req0_valid = 1;
    mid(); chk("rstx_grant", bus0.req0_ready, 1);
    nxt();
    bus0.req0_valid = 0; bus0.req1_valid = 1; rst = 1'b1;
    mid(); chk("rstx_noready", {bus0.req1_ready, bus0.req0_ready}, 0);
    nxt();
    rst = 1'b0; bus0.req1_valid = 0;
    mid();
    chk("rstx_rsp_valid", bus0.rsp_valid, 0);
    chk("rstx_busy", bus0.busy, 0);
    chk("rstx_alu_op", bus0.alu_op, ALU_ADD);
    chk("rstx_alu_a", bus0.alu_a, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); mid();
      chk("rstx_no_rsp", bus0.rsp_valid, 0);
    end
    nxt();

    // Fixed priority with anti-starvation: 0,0,0,0,1 repeating
    bus1.req0_op = ALU_SUB; bus1.req0_a = 10;   bus1.req0_b = 3;    bus1.req0_tag = 1;
    bus1.req1_op = ALU_XOR; bus1.req1_a = 'hF0; bus1.req1_b = 'h0F; bus1.req1_tag = 2;
    bus1.req0_valid = 1; bus1.req1_valid = 1; bus1.rsp_ready = 1;
    prev_src = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mid();
      if (i % 2 == 0) exp_g = ((i / 2) % 5 == 4) ? 2'b10 : 2'b01;
      else            exp_g = 2'b00;
      chk("fx_grant", {bus1.req1_ready, bus1.req0_ready}, exp_g);
      if ((i % 2 == 0) && (i > 0)) chk("fx_rsp_src", bus1.rsp_src, prev_src);
      if (i % 2 == 0) prev_src = exp_g[1];
      nxt();
    end
    bus1.req0_valid = 0; bus1.req1_valid = 0;
    mid();
    chk("fx_last_valid", bus1.rsp_valid, 1);
    chk("fx_last_src", bus1.rsp_src, 1);
    chk("fx_last_data", bus1.rsp_data, 32'hFF);
    nxt(); mid();
    chk("fx_idle", bus1.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single EX-stage ALU between two requesters: port 0 is the pipeline execute path, port 1 is an auxiliary unit such as an address generator or debug access.
- Arbitrates, registers the selected operands and 4-bit ALU op code into the ALU, captures the result, and returns it with the requester's source ID and tag over a valid/ready response channel.
- The ALU itself is external and purely combinational. This block only sequences it.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 4, requester tag width.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority to port 0 with anti-starvation.
- MAX_WAIT, 4, in ARB_MODE 1: number of consecutive port-0 grants while port 1 is pending, after which port 1 is forced.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 accepted this cycle
- req0_op  in  4  ALU op code (`ALU_* encoding)
- req0_a, req0_b  in  XLEN  operands
- req0_tag  in  TAG_W  echoed tag
- req1_valid / req1_ready / req1_op / req1_a / req1_b / req1_tag  as port 0
- alu_op  out  4  registered op code to ALU
- alu_a, alu_b  out  XLEN  registered operands to ALU
- alu_result  in  XLEN  combinational ALU result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  XLEN  captured result
- rsp_src  out  1  0 = port 0, 1 = port 1
- rsp_tag  out  TAG_W  echoed tag
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (synchronous, on a clk edge with rst=1):
  - state=IDLE; rsp_valid=0; rsp_data=0; rsp_src=0; rsp_tag=0.
  - alu_op=`ALU_ADD; alu_a=0; alu_b=0.
  - rr_ptr=0, meaning port 0 is preferred next; wait_cnt=0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any reqN_valid, grant one. reqN_ready=1 combinationally in that cycle only. At the edge, load alu_op/alu_a/alu_b, the tag and the source; go to EXEC.
  - EXEC: exactly one cycle. The ALU settles on the registered operands. At the edge, capture alu_result into rsp_data; set rsp_valid=1; go to RESP.
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready.
    - On rsp_ready=1 with a pending request: grant again in the same cycle (req ready asserted), load operands, go to EXEC.
    - On rsp_ready=1 with no pending request: go to IDLE and clear rsp_valid.
- Timing:
  - Latency: accept at edge N, rsp_valid high from edge N+2.
  - Peak throughput: one op per 2 cycles.
- req ready is never asserted in EXEC, or in RESP without rsp_ready. At most one reqN_ready is high per cycle.
- Round-robin (ARB_MODE=0):
  - Both valid: grant port rr_ptr, then rr_ptr is set to the other port.
  - Single valid: grant it, and rr_ptr is set to the other port.
- Fixed priority (ARB_MODE=1):
  - Port 0 wins unless wait_cnt==MAX_WAIT.
  - wait_cnt increments on each port-0 grant while req1_valid=1.
  - wait_cnt resets to 0 on any port-1 grant, or when req1_valid=0.
  - wait_cnt saturates at MAX_WAIT.
- Requesters must hold valid and payload until ready; the arbiter does not retract a grant.
- alu_op values outside the defined `ALU_* set pass through unchanged.
- rst asserted during EXEC or RESP: result dropped, rsp_valid=0 next cycle, no ready pulse.

Decomposition:
- `ALU_* op codes stay in the shared constant_pkg.vh.
- Add to constant_pkg.vh: state encodings ARB_IDLE=2'd0, ARB_EXEC=2'd1, ARB_RESP=2'd2, and ARB_RR=0 / ARB_FIXED=1.
- One natural sub-module, rr_arbiter2: 2-way grant logic including pointer and wait counter, purely grant/update, instantiated once.
- FSM and datapath registers stay in the top module.

Test Plan:
- Single op: req0 {op=`ALU_ADD, a=5, b=7, tag=3}, rsp_ready=1 -> req0_ready in cycle 0; alu_a=5, alu_b=7 in cycle 1; rsp_valid with rsp_data=12, rsp_src=0, rsp_tag=3 at cycle 2; back to IDLE.
- Round-robin contention: both ports continuously valid (port 0 `ALU_SUB 10,3; port 1 `ALU_XOR 0xF0,0x0F), rsp_ready=1 -> grants alternate 0,1,0,1; responses 7, 0xFF, 7, 0xFF; one grant every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles with req1 pending -> rsp_data/src/tag stable, req1_ready=0 throughout; req1 granted in the same cycle rsp_ready rises.
- Fixed priority anti-starvation: ARB_MODE=1, MAX_WAIT=4, both ports always valid -> grant pattern 0,0,0,0,1,0,0,0,0,1.
- Reset mid-operation: rst high in EXEC -> next cycle rsp_valid=0, state IDLE, alu_op=`ALU_ADD; no response ever emitted for the dropped tag.
- Idle: no valids for 10 cycles -> busy=0, no ready pulses, outputs hold their reset values.
